// File: rtl/layer_mem_arbiter.sv
// Two-master arbiter for the layer memories: ownership FSM with burst-limited
// rotation, single access per cycle, registered read return per master.
module layer_mem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [2:0]  m0_sel,
  input  logic [11:0] m0_addr,
  input  logic [19:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [2:0]  m1_sel,
  input  logic [11:0] m1_addr,
  input  logic [19:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic [19:0] m0_rdata,
  output logic [19:0] m1_rdata,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [2:0]  csel,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t      r_state, w_next;
  logic        r_last_owner;
  logic [3:0]  r_cnt, w_cnt_inc;
  logic        r_m0_vld_p1, r_m1_vld_p1;
  logic [19:0] r_m0_rdata_p1, r_m1_rdata_p1;

  logic        w_acc, w_own1, w_a_wr, w_sel_ok;
  logic [2:0]  w_a_sel;
  logic [11:0] w_a_addr;
  logic [19:0] w_a_wdata, w_rdata_in;

  // Access selection: the current owner's request is the only candidate
  assign m0_gnt    = (r_state == OWN0) && m0_req;
  assign m1_gnt    = (r_state == OWN1) && m1_req;
  assign w_acc     = m0_gnt || m1_gnt;
  assign w_own1    = (r_state == OWN1);
  assign w_a_wr    = w_own1 ? m1_wr    : m0_wr;
  assign w_a_sel   = w_own1 ? m1_sel   : m0_sel;
  assign w_a_addr  = w_own1 ? m1_addr  : m0_addr;
  assign w_a_wdata = w_own1 ? m1_wdata : m0_wdata;
  assign w_sel_ok  = (w_a_sel >= 3'd1) && (w_a_sel <= 3'd5);

  // Illegal selects are consumed silently: no strobe, and reads return zero
  assign cwr        = w_acc && w_a_wr && w_sel_ok;
  assign crd        = w_acc && !w_a_wr && w_sel_ok;
  assign csel       = (cwr || crd) ? w_a_sel : 3'd0;
  assign caddr_wr   = cwr ? w_a_addr : 12'd0;
  assign cdata_wr   = cwr ? w_a_wdata : 20'd0;
  assign caddr_rd   = crd ? w_a_addr : 12'd0;
  assign w_rdata_in = crd ? cdata_rd : 20'd0;

  assign w_cnt_inc = (r_cnt >= MAX_B) ? MAX_B : r_cnt + 4'd1;

  assign m0_rdata  = r_m0_rdata_p1;
  assign m1_rdata  = r_m1_rdata_p1;
  assign m0_rvalid = r_m0_vld_p1;
  assign m1_rvalid = r_m1_vld_p1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_req && m1_req) w_next = r_last_owner ? OWN0 : OWN1;
        else if (m0_req)      w_next = OWN0;
        else if (m1_req)      w_next = OWN1;
      end
      OWN0: begin
        if (!m0_req)                          w_next = m1_req ? OWN1 : IDLE;
        else if (m1_req && w_cnt_inc == MAX_B) w_next = OWN1;
      end
      OWN1: begin
        if (!m1_req)                          w_next = m0_req ? OWN0 : IDLE;
        else if (m0_req && w_cnt_inc == MAX_B) w_next = OWN0;
      end
      default: w_next = IDLE;
    endcase
  end

  // Stage p0 -> p1: state update and read-data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_last_owner  <= 1'b1;
      r_cnt         <= 4'd0;
      r_m0_vld_p1   <= 1'b0;
      r_m1_vld_p1   <= 1'b0;
      r_m0_rdata_p1 <= 20'd0;
      r_m1_rdata_p1 <= 20'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= 4'd0;
      else if (w_acc)        r_cnt <= w_cnt_inc;
      if (w_next == OWN0 && r_state != OWN0) r_last_owner <= 1'b0;
      if (w_next == OWN1 && r_state != OWN1) r_last_owner <= 1'b1;
      r_m0_vld_p1 <= m0_gnt && !m0_wr;
      r_m1_vld_p1 <= m1_gnt && !m1_wr;
      if (m0_gnt && !m0_wr) r_m0_rdata_p1 <= w_rdata_in;
      if (m1_gnt && !m1_wr) r_m1_rdata_p1 <= w_rdata_in;
    end
  end

endmodule

// File: doc/layer_mem_arbiter.md
LAYER_MEM_ARBITER -- requirements
Module: layer_mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_BURST, default 4, max consecutive accesses one master may issue while the other master is requesting (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-004 m0_req / m1_req  input  1  master requests one layer-memory access this cycle.
REQ-005 m0_wr / m1_wr  input  1  1 = write, 0 = read.
REQ-006 m0_sel / m1_sel  input  3  target layer-memory select (1..5 legal).
REQ-007 m0_addr / m1_addr  input  12  word address.
REQ-008 m0_wdata / m1_wdata  input  20  write data.
REQ-009 m0_gnt / m1_gnt  output  1  access accepted this cycle (combinational).
REQ-010 m0_rdata / m1_rdata  output  20  registered read data.
REQ-011 m0_rvalid / m1_rvalid  output  1  one-cycle pulse qualifying mX_rdata.
REQ-012 csel  output  3  memory select to layer memory.
REQ-013 cwr / caddr_wr / cdata_wr  output  1/12/20  write strobe, address, data.
REQ-014 crd / caddr_rd  output  1/12  read strobe, address.
REQ-015 cdata_rd  input  20  read data, valid in the same cycle as crd.

Function
REQ-016 Ownership FSM SHALL have states IDLE, OWN0, OWN1; reset state IDLE.
REQ-017 In IDLE both gnt SHALL be 0; next state: only m0_req -> OWN0; only m1_req -> OWN1; both -> master other than last_owner; none -> IDLE.
REQ-018 last_owner SHALL be a 1-bit register, reset to 1 (m0 wins first contention), updated to X on every entry into OWNX.
REQ-019 In OWNX, mX_gnt SHALL equal mX_req; the other gnt SHALL be 0.
REQ-020 An access SHALL occur in each cycle with mX_req & mX_gnt; at most one access per cycle.
REQ-021 Write access: cwr=1, crd=0, csel=mX_sel, caddr_wr=mX_addr, cdata_wr=mX_wdata.
REQ-022 Read access: crd=1, cwr=0, csel=mX_sel, caddr_rd=mX_addr; mX_rdata <= cdata_rd and mX_rvalid=1 on the next cycle.
REQ-023 Access with sel 0, 6 or 7 SHALL be granted and consumed with cwr=crd=0, csel=0; a read of that kind SHALL still pulse rvalid with rdata=0.
REQ-024 Cycles without an access SHALL drive cwr=crd=0, csel=0, caddr_wr=caddr_rd=0, cdata_wr=0.
REQ-025 A 4-bit burst counter SHALL clear on every state change and increment (saturating at MAX_BURST) per access in OWNX.
REQ-026 OWNX exit: mX_req low -> OWN(other) if other requesting, else IDLE.
REQ-027 OWNX rotation: access that brings counter to MAX_BURST while other master requests -> OWN(other) next cycle.
REQ-028 With no contention, owner SHALL keep ownership indefinitely; counter holds at MAX_BURST; rotation occurs on the first subsequent access once the other master requests.
REQ-029 Handover SHALL cost no idle cycle: the new owner's request is granted in the first cycle of OWN(other).
REQ-030 rvalid SHALL never be asserted for both masters in the same cycle.

Reset
REQ-031 While reset is low: state IDLE, last_owner=1, counter=0, all gnt/rvalid/cwr/crd=0, csel=0, all address/data outputs=0.
REQ-032 Reset asserted mid-burst SHALL abort the in-flight access; no rvalid SHALL be produced for it after release.
REQ-033 First edge after release SHALL evaluate IDLE transition rules normally.

Verification
REQ-034 m0 alone writes sel=1, addr 0x005, data 0x0ABCD -> 1 idle cycle, then m0_gnt=1, cwr=1, csel=1, caddr_wr=0x005, cdata_wr=0x0ABCD.
REQ-035 Both request from IDLE after reset, MAX_BURST=4 -> m0 gets 4 consecutive grants, m1 granted on cycle 5 with no gap, then 4 m1 grants, then m0 again.
REQ-036 m1 reads sel=3 addr 0x3FF, memory returns 0x12345 -> crd=1, caddr_rd=0x3FF that cycle; next cycle m1_rvalid=1, m1_rdata=0x12345, m0_rvalid=0.
REQ-037 m0 accesses with sel=7 -> m0_gnt=1, cwr=crd=0, csel=0; if read, m0_rvalid=1 with m0_rdata=0.
REQ-038 Reset driven low during 2nd access of an m1 read burst -> all outputs 0 immediately; after release m1_rvalid stays 0 until a new granted read.
REQ-039 m0 streams 10 writes uncontended, m1 raises req at write 7 -> m1 granted first cycle after m0's 7th access.
